// File: rtl/cbm2_keyboard.sv
// PS/2 key events to CBM-II 16x6 keyboard matrix for TPI2.
// Events pass through a 3-stage pipeline (capture, keymap lookup, apply) into a registered matrix.
module cbm2_keyboard #(
  parameter int ROWS = 6,
  parameter int COLS = 16
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [10:0]     ps2_key,
  input  logic            release_all,
  input  logic [COLS-1:0] kbd_out,
  output logic [ROWS-1:0] kbd_in,
  output logic            shift_lock,
  output logic [6:0]      keys_down
);

  logic            tog;
  logic            v0, p0_pressed, p0_ext;
  logic [7:0]      p0_code;
  logic            v1, p1_pressed, p1_hit, p1_caps;
  logic [3:0]      p1_col;
  logic [2:0]      p1_row;
  logic [7:0]      rom_q;
  logic            new_evt;
  logic            cur_bit;
  logic [COLS-1:0][ROWS-1:0] matrix, eff;
  logic [ROWS-1:0] row_hit;

  assign new_evt = ps2_key[10] != tog;

  // Keymap: {hit, col[3:0], row[2:0]} indexed by {ext, code}
  always_comb begin
    rom_q = '0;
    case ({p0_ext, p0_code})
      9'h076: rom_q = {1'b1, 4'd0,  3'd5};  9'h014: rom_q = {1'b1, 4'd0,  3'd4};
      9'h00D: rom_q = {1'b1, 4'd0,  3'd3};
      9'h016: rom_q = {1'b1, 4'd1,  3'd0};  9'h015: rom_q = {1'b1, 4'd1,  3'd1};
      9'h01E: rom_q = {1'b1, 4'd2,  3'd0};  9'h01C: rom_q = {1'b1, 4'd2,  3'd1};
      9'h01D: rom_q = {1'b1, 4'd2,  3'd2};  9'h01A: rom_q = {1'b1, 4'd2,  3'd3};
      9'h026: rom_q = {1'b1, 4'd3,  3'd0};  9'h024: rom_q = {1'b1, 4'd3,  3'd1};
      9'h01B: rom_q = {1'b1, 4'd3,  3'd2};  9'h022: rom_q = {1'b1, 4'd3,  3'd3};
      9'h025: rom_q = {1'b1, 4'd4,  3'd0};  9'h02D: rom_q = {1'b1, 4'd4,  3'd1};
      9'h023: rom_q = {1'b1, 4'd4,  3'd2};  9'h021: rom_q = {1'b1, 4'd4,  3'd3};
      9'h02E: rom_q = {1'b1, 4'd5,  3'd0};  9'h02C: rom_q = {1'b1, 4'd5,  3'd1};
      9'h02B: rom_q = {1'b1, 4'd5,  3'd2};  9'h02A: rom_q = {1'b1, 4'd5,  3'd3};
      9'h036: rom_q = {1'b1, 4'd6,  3'd0};  9'h035: rom_q = {1'b1, 4'd6,  3'd1};
      9'h034: rom_q = {1'b1, 4'd6,  3'd2};  9'h032: rom_q = {1'b1, 4'd6,  3'd3};
      9'h175: rom_q = {1'b1, 4'd6,  3'd5};
      9'h03D: rom_q = {1'b1, 4'd7,  3'd0};  9'h03C: rom_q = {1'b1, 4'd7,  3'd1};
      9'h033: rom_q = {1'b1, 4'd7,  3'd2};  9'h031: rom_q = {1'b1, 4'd7,  3'd3};
      9'h172: rom_q = {1'b1, 4'd7,  3'd5};
      9'h03E: rom_q = {1'b1, 4'd8,  3'd0};  9'h043: rom_q = {1'b1, 4'd8,  3'd1};
      9'h03B: rom_q = {1'b1, 4'd8,  3'd2};  9'h03A: rom_q = {1'b1, 4'd8,  3'd3};
      9'h012: rom_q = {1'b1, 4'd8,  3'd4};  9'h16B: rom_q = {1'b1, 4'd8,  3'd5};
      9'h046: rom_q = {1'b1, 4'd9,  3'd0};  9'h044: rom_q = {1'b1, 4'd9,  3'd1};
      9'h042: rom_q = {1'b1, 4'd9,  3'd2};  9'h041: rom_q = {1'b1, 4'd9,  3'd3};
      9'h174: rom_q = {1'b1, 4'd9,  3'd5};
      9'h045: rom_q = {1'b1, 4'd10, 3'd0};  9'h04D: rom_q = {1'b1, 4'd10, 3'd1};
      9'h04B: rom_q = {1'b1, 4'd10, 3'd2};  9'h05A: rom_q = {1'b1, 4'd10, 3'd3};
      9'h059: rom_q = {1'b1, 4'd11, 3'd3};  9'h029: rom_q = {1'b1, 4'd11, 3'd4};
      9'h066: rom_q = {1'b1, 4'd12, 3'd0};
      default: rom_q = '0;
    endcase
  end

  // Shift lock appears as a held left shift (col 8, row 4) without touching the matrix
  always_comb begin
    eff = matrix;
    eff[8][4] = matrix[8][4] | shift_lock;
  end

  always_comb begin
    row_hit = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        row_hit[r] = row_hit[r] | (~kbd_out[c] & eff[c][r]);
      end
    end
  end

  assign cur_bit = matrix[p1_col][p1_row];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog <= ps2_key[10];
      v0  <= 1'b0;
    end else begin
      v0 <= new_evt;
      if (new_evt) begin
        tog        <= ps2_key[10];
        p0_pressed <= ps2_key[9];
        p0_ext     <= ps2_key[8];
        p0_code    <= ps2_key[7:0];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) v1 <= 1'b0;
    else       v1 <= v0;
    p1_pressed <= p0_pressed;
    p1_hit     <= rom_q[7];
    p1_col     <= rom_q[6:3];
    p1_row     <= rom_q[2:0];
    p1_caps    <= ({p0_ext, p0_code} == 9'h058);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      matrix     <= '0;
      shift_lock <= 1'b0;
      keys_down  <= '0;
      kbd_in     <= '1;
    end else begin
      kbd_in <= ~row_hit;
      if (release_all) begin
        matrix     <= '0;
        shift_lock <= 1'b0;
        keys_down  <= '0;
      end else if (v1) begin
        if (p1_caps) begin
          if (p1_pressed) shift_lock <= ~shift_lock;
        end else if (p1_hit) begin
          if (p1_pressed && !cur_bit) begin
            matrix[p1_col][p1_row] <= 1'b1;
            keys_down <= keys_down + 7'd1;
          end else if (!p1_pressed && cur_bit) begin
            matrix[p1_col][p1_row] <= 1'b0;
            keys_down <= keys_down - 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cbm2_keyboard.sv
// Directed self-checking bench for cbm2_keyboard.
module tb_cbm2_keyboard;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic        release_all;
  logic [15:0] kbd_out;
  logic [5:0]  kbd_in;
  logic        shift_lock;
  logic [6:0]  keys_down;

  int unsigned total = 0;
  int unsigned bad   = 0;

  cbm2_keyboard #(.ROWS(6), .COLS(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .release_all (release_all),
    .kbd_out     (kbd_out),
    .kbd_in      (kbd_in),
    .shift_lock  (shift_lock),
    .keys_down   (keys_down)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic flip(input logic p, input logic e, input logic [7:0] code);
    ps2_key = {~ps2_key[10], p, e, code};
  endtask

  // One event, then wait until it has been applied to the matrix
  task automatic key(input logic p, input logic e, input logic [7:0] code);
    flip(p, e, code);
    tick(); tick(); tick();
  endtask

  initial begin
    reset = 1'b1; ps2_key = '0; release_all = 1'b0; kbd_out = 16'hFFFF;
    tick(); tick();
    reset = 1'b0;
    chk("rst_kbd_in", kbd_in, 6'h3F);
    chk("rst_lock", shift_lock, 1'b0);
    chk("rst_keys", keys_down, 7'd0);

    // 'A' make, column 2 selected
    kbd_out = 16'hFFFB;
    key(1'b1, 1'b0, 8'h1C);
    chk("a_keys", keys_down, 7'd1);
    tick();
    chk("a_row1", kbd_in, 6'h3D);
    kbd_out = 16'hFFFF;
    tick();
    chk("a_nosel", kbd_in, 6'h3F);

    // typematic repeats and breaks
    key(1'b0, 1'b0, 8'h1C);
    chk("a_brk0", keys_down, 7'd0);
    key(1'b1, 1'b0, 8'h1C); chk("rep1", keys_down, 7'd1);
    key(1'b1, 1'b0, 8'h1C); chk("rep2", keys_down, 7'd1);
    key(1'b1, 1'b0, 8'h1C); chk("rep3", keys_down, 7'd1);
    key(1'b0, 1'b0, 8'h1C); chk("rep_brk", keys_down, 7'd0);
    key(1'b0, 1'b0, 8'h1C); chk("brk_unpressed", keys_down, 7'd0);
    kbd_out = 16'hFFFB;
    tick();
    chk("a_gone", kbd_in, 6'h3F);

    // unmapped code and extended vs plain 0x75
    key(1'b1, 1'b0, 8'h0E);
    kbd_out = 16'h0000;
    tick();
    chk("unmap_keys", keys_down, 7'd0);
    chk("unmap_kbd", kbd_in, 6'h3F);
    key(1'b1, 1'b0, 8'h75);
    kbd_out = 16'hFFBF;
    tick();
    chk("plain75_kbd", kbd_in, 6'h3F);
    chk("plain75_keys", keys_down, 7'd0);
    key(1'b1, 1'b1, 8'h75);
    tick();
    chk("up_kbd", kbd_in, 6'h1F);
    chk("up_keys", keys_down, 7'd1);
    key(1'b0, 1'b1, 8'h75);
    tick();
    chk("up_brk_kbd", kbd_in, 6'h3F);
    chk("up_brk_keys", keys_down, 7'd0);

    // caps lock
    key(1'b1, 1'b0, 8'h58); chk("caps_on", shift_lock, 1'b1);
    key(1'b0, 1'b0, 8'h58); chk("caps_brk", shift_lock, 1'b1);
    kbd_out = 16'hFEFF;
    tick();
    chk("caps_kbd", kbd_in, 6'h2F);
    chk("caps_keys", keys_down, 7'd0);
    key(1'b1, 1'b0, 8'h58); chk("caps_off", shift_lock, 1'b0);
    key(1'b0, 1'b0, 8'h58); chk("caps_brk2", shift_lock, 1'b0);
    tick();
    chk("caps_off_kbd", kbd_in, 6'h3F);

    // back-to-back events: '1', 'A', Return
    flip(1'b1, 1'b0, 8'h16); tick();
    flip(1'b1, 1'b0, 8'h1C); tick();
    flip(1'b1, 1'b0, 8'h5A); tick();
    tick(); tick();
    chk("b2b_keys", keys_down, 7'd3);
    kbd_out = 16'h0000;
    tick();
    chk("b2b_kbd", kbd_in, 6'h34);
    release_all = 1'b1; tick(); release_all = 1'b0;
    chk("rel_keys", keys_down, 7'd0);
    tick();
    chk("rel_kbd", kbd_in, 6'h3F);

    // release_all with Return in stage 2 and Esc in stage 1
    key(1'b1, 1'b0, 8'h1C);
    chk("a2_keys", keys_down, 7'd1);
    flip(1'b1, 1'b0, 8'h5A); tick();
    flip(1'b1, 1'b0, 8'h76); tick();
    release_all = 1'b1; tick(); release_all = 1'b0;
    chk("relmid_keys", keys_down, 7'd0);
    tick();
    chk("esc_keys", keys_down, 7'd1);
    tick();
    chk("esc_kbd", kbd_in, 6'h1F);
    tick(); tick();
    chk("ret_dropped", keys_down, 7'd1);
    release_all = 1'b1; tick(); release_all = 1'b0;
    tick();
    chk("clean_kbd", kbd_in, 6'h3F);

    // reset mid-pipeline: event lost, not replayed
    flip(1'b1, 1'b0, 8'h1C); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rstmid_keys", keys_down, 7'd0);
    chk("rstmid_kbd", kbd_in, 6'h3F);
    key(1'b1, 1'b0, 8'h1C);
    chk("post_rst_keys", keys_down, 7'd1);
    tick();
    chk("post_rst_kbd", kbd_in, 6'h3D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
